// File: rtl/if_pkg.sv
// Shared definitions for the instruction-fetch stage.
package if_pkg;

    // Fetch FSM states.
    typedef enum logic [1:0] {
        StIdle,
        StFetch,
        StDrain,
        StHold
    } if_state_e;

    // Redirect select codes from ID; code 3 is treated as sequential.
    localparam logic [1:0] PC_SRC_SEQ    = 2'd0;
    localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
    localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

    // An all-zero word is the NOP seen by ID.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/if_pc_select.sv
// Decodes the ID redirect request into a valid flag and a target address.
module if_pc_select
    import if_pkg::*;
(
    input  logic        hazard_i,
    input  logic [1:0]  pc_source_i,
    input  logic [31:0] branch_addr_i,
    input  logic [31:0] jump_addr_i,
    output logic        redirect_o,
    output logic [31:0] target_o
);

    // A stall suppresses any redirect; otherwise only branch and jump redirect.
    always_comb begin
        redirect_o = 1'b0;
        target_o   = branch_addr_i;
        if (!hazard_i) begin
            case (pc_source_i)
                PC_SRC_SEQ: begin
                    redirect_o = 1'b0;
                end
                PC_SRC_BRANCH: begin
                    redirect_o = 1'b1;
                    target_o   = branch_addr_i;
                end
                PC_SRC_JUMP: begin
                    redirect_o = 1'b1;
                    target_o   = jump_addr_i;
                end
                default: begin
                    redirect_o = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, req/ack fetch FSM and the IF/ID register.
module if_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hazard,
    input  logic [1:0]  if_pc_source,
    input  logic [31:0] branch_addr,
    input  logic [31:0] jump_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IF_ID_instruction,
    output logic [31:0] IF_ID_next_i_addr
);

    if_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] redir_pc_q, redir_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;
    logic [31:0] hold_next_q, hold_next_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic [31:0] ifid_next_q, ifid_next_d;

    logic        redirect;
    logic [31:0] target;
    logic [31:0] pc_plus4;

    if_pc_select u_pc_select (
        .hazard_i      (hazard),
        .pc_source_i   (if_pc_source),
        .branch_addr_i (branch_addr),
        .jump_addr_i   (jump_addr),
        .redirect_o    (redirect),
        .target_o      (target)
    );

    assign pc_plus4 = pc_q + 32'd4;

    // Memory-side outputs come from registers only, never from imem_ack.
    assign imem_req          = (state_q == StFetch) || (state_q == StDrain);
    assign imem_addr         = pc_q;
    assign IF_ID_instruction = ifid_instr_q;
    assign IF_ID_next_i_addr = ifid_next_q;

    // Next-state logic for the fetch FSM, PC and IF/ID register.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        redir_pc_d   = redir_pc_q;
        hold_instr_d = hold_instr_q;
        hold_next_d  = hold_next_q;
        ifid_instr_d = ifid_instr_q;
        ifid_next_d  = ifid_next_q;

        unique case (state_q)
            StIdle: begin
                state_d = StFetch;
                if (redirect) begin
                    pc_d         = target;
                    ifid_instr_d = NOP_INSTR;
                end
            end
            StFetch: begin
                if (redirect) begin
                    ifid_instr_d = NOP_INSTR;
                    if (imem_ack) begin
                        pc_d = target;
                    end else begin
                        redir_pc_d = target;
                        state_d    = StDrain;
                    end
                end else if (imem_ack) begin
                    pc_d = pc_plus4;
                    if (hazard) begin
                        // ID is stalled: park the word until it can be accepted.
                        hold_instr_d = imem_rdata;
                        hold_next_d  = pc_plus4;
                        state_d      = StHold;
                    end else begin
                        ifid_instr_d = imem_rdata;
                        ifid_next_d  = pc_plus4;
                    end
                end else if (!hazard) begin
                    ifid_instr_d = NOP_INSTR;
                end
            end
            StDrain: begin
                // Keep the old address on the bus until the pending access completes.
                if (redirect) begin
                    redir_pc_d = target;
                end
                if (!hazard) begin
                    ifid_instr_d = NOP_INSTR;
                end
                if (imem_ack) begin
                    pc_d    = redirect ? target : redir_pc_q;
                    state_d = StFetch;
                end
            end
            StHold: begin
                if (!hazard) begin
                    state_d = StFetch;
                    if (redirect) begin
                        pc_d         = target;
                        ifid_instr_d = NOP_INSTR;
                    end else begin
                        ifid_instr_d = hold_instr_q;
                        ifid_next_d  = hold_next_q;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            redir_pc_q   <= 32'h0;
            hold_instr_q <= 32'h0;
            hold_next_q  <= 32'h0;
            ifid_instr_q <= NOP_INSTR;
            ifid_next_q  <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            redir_pc_q   <= redir_pc_d;
            hold_instr_q <= hold_instr_d;
            hold_next_q  <= hold_next_d;
            ifid_instr_q <= ifid_instr_d;
            ifid_next_q  <= ifid_next_d;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage.
module tb_if_stage;

    logic        clk;
    logic        rst_n;
    logic        hazard;
    logic [1:0]  if_pc_source;
    logic [31:0] branch_addr;
    logic [31:0] jump_addr;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] IF_ID_instruction;
    logic [31:0] IF_ID_next_i_addr;

    logic        zero_wait;
    logic        ack_drv;
    int          vecs;
    int          errs;

    // Memory model: word at address A is A ^ 32'hDEAD_0000.
    assign imem_ack   = zero_wait ? imem_req : ack_drv;
    assign imem_rdata = imem_addr ^ 32'hDEAD_0000;

    if_stage #(
        .RESET_PC (32'h0000_0100)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .hazard            (hazard),
        .if_pc_source      (if_pc_source),
        .branch_addr       (branch_addr),
        .jump_addr         (jump_addr),
        .imem_req          (imem_req),
        .imem_addr         (imem_addr),
        .imem_ack          (imem_ack),
        .imem_rdata        (imem_rdata),
        .IF_ID_instruction (IF_ID_instruction),
        .IF_ID_next_i_addr (IF_ID_next_i_addr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; zero_wait = 1'b1; ack_drv = 1'b0; hazard = 1'b0;
        if_pc_source = 2'd0; branch_addr = 32'h0; jump_addr = 32'h0;
        step(); step();
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rst_req got %h exp 0", imem_req); end
        vecs++; if (imem_addr !== 32'h100) begin errs++; $display("FAIL rst_addr got %h exp 00000100", imem_addr); end
        vecs++; if (IF_ID_instruction !== 32'h0) begin errs++; $display("FAIL rst_instr got %h exp 0", IF_ID_instruction); end
        vecs++; if (IF_ID_next_i_addr !== 32'h0) begin errs++; $display("FAIL rst_next got %h exp 0", IF_ID_next_i_addr); end
    endtask

    task automatic test_zero_wait();
        logic [31:0] a;
        rst_n = 1'b1;
        step();
        vecs++; if (imem_req !== 1'b1) begin errs++; $display("FAIL zw_first_req got %h exp 1", imem_req); end
        vecs++; if (imem_addr !== 32'h100) begin errs++; $display("FAIL zw_first_addr got %h exp 00000100", imem_addr); end
        for (int i = 0; i < 3; i++) begin
            a = 32'h100 + 32'(4 * i);
            step();
            vecs++; if (IF_ID_instruction !== (a ^ 32'hDEAD_0000)) begin errs++; $display("FAIL zw_instr[%0d] got %h exp %h", i, IF_ID_instruction, a ^ 32'hDEAD_0000); end
            vecs++; if (IF_ID_next_i_addr !== a + 32'd4) begin errs++; $display("FAIL zw_next[%0d] got %h exp %h", i, IF_ID_next_i_addr, a + 32'd4); end
            vecs++; if (imem_addr !== a + 32'd4) begin errs++; $display("FAIL zw_addr[%0d] got %h exp %h", i, imem_addr, a + 32'd4); end
        end
    endtask

    task automatic test_src3();
        // PC is 0x10C here; code 3 must advance sequentially.
        if_pc_source = 2'd3; branch_addr = 32'h400; jump_addr = 32'h500;
        step();
        if_pc_source = 2'd0;
        vecs++; if (IF_ID_instruction !== 32'hDEAD_010C) begin errs++; $display("FAIL src3_instr got %h exp dead010c", IF_ID_instruction); end
        vecs++; if (imem_addr !== 32'h110) begin errs++; $display("FAIL src3_addr got %h exp 00000110", imem_addr); end
    endtask

    task automatic test_branch_zw();
        if_pc_source = 2'd1; branch_addr = 32'h400;
        step();
        if_pc_source = 2'd0;
        vecs++; if (IF_ID_instruction !== 32'h0) begin errs++; $display("FAIL br_flush got %h exp 0", IF_ID_instruction); end
        vecs++; if (imem_addr !== 32'h400) begin errs++; $display("FAIL br_addr got %h exp 00000400", imem_addr); end
        step();
        vecs++; if (IF_ID_instruction !== 32'hDEAD_0400) begin errs++; $display("FAIL br_instr got %h exp dead0400", IF_ID_instruction); end
        vecs++; if (IF_ID_next_i_addr !== 32'h404) begin errs++; $display("FAIL br_next got %h exp 00000404", IF_ID_next_i_addr); end
    endtask

    task automatic test_redirect_hazard();
        // Jump requested under hazard at 0x404 must be ignored; ack goes to HOLD.
        hazard = 1'b1; if_pc_source = 2'd2; jump_addr = 32'h800;
        step();
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL rh_req got %h exp 0", imem_req); end
        vecs++; if (imem_addr !== 32'h408) begin errs++; $display("FAIL rh_addr got %h exp 00000408", imem_addr); end
        vecs++; if (IF_ID_instruction !== 32'hDEAD_0400) begin errs++; $display("FAIL rh_frozen got %h exp dead0400", IF_ID_instruction); end
        hazard = 1'b0; if_pc_source = 2'd0;
        step();
        vecs++; if (IF_ID_instruction !== 32'hDEAD_0404) begin errs++; $display("FAIL rh_release got %h exp dead0404", IF_ID_instruction); end
        vecs++; if (imem_addr !== 32'h408) begin errs++; $display("FAIL rh_next_fetch got %h exp 00000408", imem_addr); end
    endtask

    task automatic test_load_use();
        if_pc_source = 2'd2; jump_addr = 32'h200;
        step();
        if_pc_source = 2'd0; hazard = 1'b1;
        step();
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL lu_req1 got %h exp 0", imem_req); end
        vecs++; if (IF_ID_instruction !== 32'h0) begin errs++; $display("FAIL lu_frozen1 got %h exp 0", IF_ID_instruction); end
        step();
        vecs++; if (imem_req !== 1'b0) begin errs++; $display("FAIL lu_req2 got %h exp 0", imem_req); end
        vecs++; if (IF_ID_instruction !== 32'h0) begin errs++; $display("FAIL lu_frozen2 got %h exp 0", IF_ID_instruction); end
        hazard = 1'b0;
        step();
        vecs++; if (IF_ID_instruction !== 32'hDEAD_0200) begin errs++; $display("FAIL lu_instr got %h exp dead0200", IF_ID_instruction); end
        vecs++; if (IF_ID_next_i_addr !== 32'h204) begin errs++; $display("FAIL lu_next got %h exp 00000204", IF_ID_next_i_addr); end
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h204) begin errs++; $display("FAIL lu_fetch got req %h addr %h exp req 1 addr 00000204", imem_req, imem_addr); end
    endtask

    task automatic test_var_latency();
        logic [31:0] a;
        zero_wait = 1'b0; ack_drv = 1'b0;
        for (int i = 0; i < 2; i++) begin
            a = 32'h204 + 32'(4 * i);
            for (int w = 0; w < 2; w++) begin
                step();
                vecs++; if (IF_ID_instruction !== 32'h0) begin errs++; $display("FAIL vl_bubble[%0d.%0d] got %h exp 0", i, w, IF_ID_instruction); end
                vecs++; if (imem_addr !== a || imem_req !== 1'b1) begin errs++; $display("FAIL vl_stable[%0d.%0d] got addr %h req %h exp %h 1", i, w, imem_addr, imem_req, a); end
            end
            ack_drv = 1'b1;
            step();
            ack_drv = 1'b0;
            vecs++; if (IF_ID_instruction !== (a ^ 32'hDEAD_0000)) begin errs++; $display("FAIL vl_instr[%0d] got %h exp %h", i, IF_ID_instruction, a ^ 32'hDEAD_0000); end
            vecs++; if (IF_ID_next_i_addr !== a + 32'd4) begin errs++; $display("FAIL vl_next[%0d] got %h exp %h", i, IF_ID_next_i_addr, a + 32'd4); end
        end
    endtask

    task automatic test_jump_drain();
        // Redirect with ack to 0x300, then two jumps while 0x300 is outstanding.
        ack_drv = 1'b1; if_pc_source = 2'd2; jump_addr = 32'h300;
        step();
        ack_drv = 1'b0; jump_addr = 32'h800;
        step();
        if_pc_source = 2'd0;
        vecs++; if (imem_addr !== 32'h300 || imem_req !== 1'b1) begin errs++; $display("FAIL jd_hold1 got addr %h req %h exp 00000300 1", imem_addr, imem_req); end
        step();
        vecs++; if (imem_addr !== 32'h300) begin errs++; $display("FAIL jd_hold2 got %h exp 00000300", imem_addr); end
        vecs++; if (IF_ID_instruction !== 32'h0) begin errs++; $display("FAIL jd_bubble got %h exp 0", IF_ID_instruction); end
        if_pc_source = 2'd2; jump_addr = 32'h900;
        step();
        if_pc_source = 2'd0; ack_drv = 1'b1;
        step();
        vecs++; if (imem_addr !== 32'h900) begin errs++; $display("FAIL jd_target got %h exp 00000900", imem_addr); end
        vecs++; if (IF_ID_instruction !== 32'h0) begin errs++; $display("FAIL jd_discard got %h exp 0", IF_ID_instruction); end
        step();
        ack_drv = 1'b0;
        vecs++; if (IF_ID_instruction !== 32'hDEAD_0900) begin errs++; $display("FAIL jd_instr got %h exp dead0900", IF_ID_instruction); end
    endtask

    task automatic test_reset_in_drain();
        // PC is 0x904, no ack: branch enters DRAIN, then reset.
        if_pc_source = 2'd1; branch_addr = 32'hA00;
        step();
        if_pc_source = 2'd0; rst_n = 1'b0;
        step();
        vecs++; if (imem_req !== 1'b0 || imem_addr !== 32'h100) begin errs++; $display("FAIL rd_reset got req %h addr %h exp 0 00000100", imem_req, imem_addr); end
        rst_n = 1'b1; ack_drv = 1'b1;
        step();
        ack_drv = 1'b0;
        vecs++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errs++; $display("FAIL rd_late_ack got req %h addr %h exp 1 00000100", imem_req, imem_addr); end
        vecs++; if (IF_ID_instruction !== 32'h0) begin errs++; $display("FAIL rd_instr got %h exp 0", IF_ID_instruction); end
        step();
        vecs++; if (imem_addr !== 32'h100 || IF_ID_instruction !== 32'h0) begin errs++; $display("FAIL rd_wait got addr %h instr %h exp 00000100 0", imem_addr, IF_ID_instruction); end
    endtask

    task automatic test_wrap();
        zero_wait = 1'b1; if_pc_source = 2'd2; jump_addr = 32'hFFFF_FFFC;
        step();
        if_pc_source = 2'd0;
        vecs++; if (imem_addr !== 32'hFFFF_FFFC) begin errs++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); end
        step();
        vecs++; if (IF_ID_instruction !== 32'h2152_FFFC) begin errs++; $display("FAIL wrap_instr got %h exp 2152fffc", IF_ID_instruction); end
        vecs++; if (IF_ID_next_i_addr !== 32'h0 || imem_addr !== 32'h0) begin errs++; $display("FAIL wrap_next got next %h addr %h exp 0 0", IF_ID_next_i_addr, imem_addr); end
    endtask

    initial begin
        vecs = 0;
        errs = 0;
        test_reset();
        test_zero_wait();
        test_src3();
        test_branch_zw();
        test_redirect_hazard();
        test_load_use();
        test_var_latency();
        test_jump_drain();
        test_reset_in_drain();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
